// File: rtl/axi_fifo_drain_ctrl.sv
// axi_fifo_drain_ctrl: drains outstanding AXI traffic toward a downstream FIFO
// and then isolates the path, gating only valid/ready while payloads pass through.
// Optional feature: define AXI_FIFO_DRAIN_TIMEOUT_EN to add the timeout_o port
// and the drain cycle counter behind it.
// The default request/response types below describe the struct shape the
// controller expects (aw/w/ar channels, b/r responses, valid/ready members).

typedef struct packed {
  logic [3:0]  id;
  logic [31:0] addr;
} axi_fdc_ax_t;

typedef struct packed {
  logic [31:0] data;
  logic        last;
} axi_fdc_w_t;

typedef struct packed {
  logic [3:0] id;
  logic [1:0] resp;
} axi_fdc_b_t;

typedef struct packed {
  logic [3:0]  id;
  logic [31:0] data;
  logic [1:0]  resp;
  logic        last;
} axi_fdc_r_t;

typedef struct packed {
  axi_fdc_ax_t aw;
  logic        aw_valid;
  axi_fdc_w_t  w;
  logic        w_valid;
  logic        b_ready;
  axi_fdc_ax_t ar;
  logic        ar_valid;
  logic        r_ready;
} axi_fdc_req_t;

typedef struct packed {
  logic       aw_ready;
  logic       ar_ready;
  logic       w_ready;
  axi_fdc_b_t b;
  logic       b_valid;
  axi_fdc_r_t r;
  logic       r_valid;
} axi_fdc_resp_t;

module axi_fifo_drain_ctrl #(
  parameter int unsigned MaxTxn        = 32'd8,
  parameter int unsigned TimeoutCycles = 32'd1024,
  parameter type         axi_req_t     = axi_fdc_req_t,
  parameter type         axi_resp_t    = axi_fdc_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      isolate_i,
  output logic      isolated_o,
`ifdef AXI_FIFO_DRAIN_TIMEOUT_EN
  output logic      timeout_o,
`endif
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  localparam int unsigned CntW = $clog2(MaxTxn + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxn);

  if (MaxTxn < 1 || TimeoutCycles < 1) begin : g_param_check
    $error("axi_fifo_drain_ctrl: MaxTxn and TimeoutCycles must be at least 1");
  end

  typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, rd_cnt_q, w_cnt_q;
  logic aw_en, ar_en, w_en, resp_en;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

  // Saturating up/down step; simultaneous increment and decrement cancel out.
  function automatic logic [CntW-1:0] step_cnt(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    step_cnt = cnt;
    if (inc && !dec && cnt != MaxCnt) begin
      step_cnt = cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      step_cnt = cnt - 1'b1;
    end
  endfunction

  // Pass payloads straight through and gate only the handshake signals by state.
  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    aw_en   = (state_q == NORMAL) && (wr_cnt_q != MaxCnt);
    ar_en   = (state_q == NORMAL) && (rd_cnt_q != MaxCnt);
    w_en    = (state_q == NORMAL) || ((state_q == DRAIN) && (w_cnt_q != '0));
    resp_en = (state_q != ISOLATED);
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_en;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_en;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_en;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_en;
    mst_req_o.w_valid   = slv_req_i.w_valid & w_en;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_en;
    mst_req_o.b_ready   = slv_req_i.b_ready & resp_en;
    slv_resp_o.b_valid  = mst_resp_i.b_valid & resp_en;
    mst_req_o.r_ready   = slv_req_i.r_ready & resp_en;
    slv_resp_o.r_valid  = mst_resp_i.r_valid & resp_en;
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
  assign b_hs      = slv_resp_o.b_valid & slv_req_i.b_ready;
  assign r_last_hs = slv_resp_o.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  // Track outstanding writes, reads and write bursts still owed their last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      w_cnt_q  <= '0;
    end else begin
      wr_cnt_q <= step_cnt(wr_cnt_q, aw_hs, b_hs);
      rd_cnt_q <= step_cnt(rd_cnt_q, ar_hs, r_last_hs);
      w_cnt_q  <= step_cnt(w_cnt_q, aw_hs, w_last_hs);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping isolate_i always wins and returns to NORMAL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: begin
        if (isolate_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!isolate_i) begin
          state_d = NORMAL;
        end else if (wr_cnt_q == '0 && rd_cnt_q == '0 && w_cnt_q == '0) begin
          state_d = ISOLATED;
        end
      end
      ISOLATED: begin
        if (!isolate_i) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign isolated_o = (state_q == ISOLATED);

`ifdef AXI_FIFO_DRAIN_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TimeoutCycles);

  logic [TmoW-1:0] tmo_cnt_q;

  // Count cycles spent in DRAIN, saturating at the threshold; cleared outside DRAIN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q != DRAIN) begin
      tmo_cnt_q <= '0;
    end else if (tmo_cnt_q != TmoMax) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_o = (state_q == DRAIN) && (tmo_cnt_q == TmoMax);
`endif

endmodule

// File: tb/tb_axi_fifo_drain_ctrl.sv
// tb_axi_fifo_drain_ctrl: directed scoreboard bench for axi_fifo_drain_ctrl
// with MaxTxn=2; the timeout scenario is built when AXI_FIFO_DRAIN_TIMEOUT_EN is defined.
module tb_axi_fifo_drain_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic isolate;
  logic isolated;
`ifdef AXI_FIFO_DRAIN_TIMEOUT_EN
  logic timeout;
`endif
  axi_fdc_req_t  slv_req, mst_req;
  axi_fdc_resp_t slv_resp, mst_resp;

  int errors = 0;
  int checks = 0;

  logic [31:0] aw_q[$];
  logic [32:0] w_q[$];
  logic [31:0] ar_q[$];
  logic [3:0]  b_q[$];
  logic [31:0] r_q[$];

  always #5 clk = ~clk;

  axi_fifo_drain_ctrl #(
    .MaxTxn       (2),
    .TimeoutCycles(16)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .isolate_i (isolate),
    .isolated_o(isolated),
`ifdef AXI_FIFO_DRAIN_TIMEOUT_EN
    .timeout_o (timeout),
`endif
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake the DUT presents must match the next expected item.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        check_output("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) check_output("aw_addr", mst_req.aw.addr, aw_q.pop_front());
      end
      if (mst_req.w_valid && mst_resp.w_ready) begin
        check_output("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) check_output("w_beat", {mst_req.w.last, mst_req.w.data}, w_q.pop_front());
      end
      if (mst_req.ar_valid && mst_resp.ar_ready) begin
        check_output("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) check_output("ar_addr", mst_req.ar.addr, ar_q.pop_front());
      end
      if (slv_resp.b_valid && slv_req.b_ready) begin
        check_output("b_expected", b_q.size() != 0, 1);
        if (b_q.size() != 0) check_output("b_id", slv_resp.b.id, b_q.pop_front());
      end
      if (slv_resp.r_valid && slv_req.r_ready) begin
        check_output("r_expected", r_q.size() != 0, 1);
        if (r_q.size() != 0) check_output("r_data", slv_resp.r.data, r_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic exp_rdy);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = addr;
    #1 check_output("aw_ready", slv_resp.aw_ready, exp_rdy);
    if (exp_rdy) aw_q.push_back(addr);
    tick();
    slv_req.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic last, input logic exp_rdy);
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = data;
    slv_req.w.last  = last;
    #1 check_output("w_ready", slv_resp.w_ready, exp_rdy);
    if (exp_rdy) w_q.push_back({last, data});
    tick();
    slv_req.w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = addr;
    #1 check_output("ar_ready", slv_resp.ar_ready, 1);
    ar_q.push_back(addr);
    tick();
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = id;
    #1 check_output("b_valid", slv_resp.b_valid, 1);
    b_q.push_back(id);
    tick();
    mst_resp.b_valid = 1'b0;
  endtask

  task automatic send_r(input logic [31:0] data);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.data  = data;
    mst_resp.r.last  = 1'b1;
    #1 check_output("r_valid", slv_resp.r_valid, 1);
    r_q.push_back(data);
    tick();
    mst_resp.r_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    isolate  = 1'b0;
    rst_n    = 1'b0;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.ar_ready = 1'b1;

    // Reset: outputs look like NORMAL with empty counters.
    slv_req.aw_valid = 1'b1;
    #2;
    check_output("rst_isolated", isolated, 0);
    check_output("rst_aw_ready", slv_resp.aw_ready, 1);
    check_output("rst_aw_valid", mst_req.aw_valid, 1);
    slv_req.aw_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Outstanding-write limit: third AW waits for a B.
    send_aw(32'hA000_0000, 1);
    send_w(32'hD000_0000, 1, 1);
    send_aw(32'hA000_0001, 1);
    send_w(32'hD000_0001, 1, 1);
    send_aw(32'hA000_0002, 0);
    send_b(4'h1);
    send_aw(32'hA000_0002, 1);
    send_w(32'hD000_0002, 1, 1);
    send_b(4'h2);
    send_b(4'h3);

    // Idle isolation: two edges, then everything gated.
    isolate = 1'b1;
    tick();
    check_output("iso_edge1", isolated, 0);
    tick();
    check_output("iso_edge2", isolated, 1);
    slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1; slv_req.ar_valid = 1'b1;
    mst_resp.b_valid = 1'b1; mst_resp.r_valid = 1'b1;
    #1;
    check_output("iso_gates", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                               mst_req.b_ready, mst_req.r_ready, slv_resp.aw_ready,
                               slv_resp.w_ready, slv_resp.ar_ready, slv_resp.b_valid,
                               slv_resp.r_valid}, 0);
    tick();
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b0; slv_req.ar_valid = 1'b0;
    mst_resp.b_valid = 1'b0; mst_resp.r_valid = 1'b0;
    isolate = 1'b0;
    tick();
    check_output("iso_release", isolated, 0);

    // Drain with two 4-beat bursts owed.
    send_aw(32'hB000_0000, 1);
    send_aw(32'hB000_0001, 1);
    isolate = 1'b1;
    tick();
    send_aw(32'hB000_0002, 0);
    for (int i = 0; i < 8; i++) send_w(32'hC000_0000 + i, (i % 4) == 3, 1);
    send_w(32'hC0FF_FFFF, 1, 0);
    check_output("drain_wait_b0", isolated, 0);
    send_b(4'h4);
    check_output("drain_wait_b1", isolated, 0);
    send_b(4'h5);
    check_output("drain_last_b", isolated, 0);
    tick();
    check_output("drain_done", isolated, 1);
    isolate = 1'b0;
    tick();

    // Same-cycle AR and R-last keep the read count steady.
    send_ar(32'hE000_0000);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 32'hE000_0001;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.data  = 32'h1111_0000;
    mst_resp.r.last  = 1'b1;
    #1;
    check_output("ar_r_ar_ready", slv_resp.ar_ready, 1);
    check_output("ar_r_r_valid", slv_resp.r_valid, 1);
    ar_q.push_back(32'hE000_0001);
    r_q.push_back(32'h1111_0000);
    tick();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    isolate = 1'b1;
    tick();
    tick();
    check_output("rd_hold_no_iso", isolated, 0);
    send_r(32'h1111_0001);
    check_output("rd_last_pending", isolated, 0);
    tick();
    check_output("rd_iso", isolated, 1);
    isolate = 1'b0;
    tick();

    // Abort a drain, then reset mid-DRAIN and mid-ISOLATED.
    send_aw(32'hF000_0000, 1);
    isolate = 1'b1;
    tick();
    isolate = 1'b0;
    tick();
    send_aw(32'hF000_0001, 1);
    isolate = 1'b1;
    tick();
    tick();
    check_output("stuck_drain", isolated, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_output("iso_after_reset", isolated, 1);
    rst_n = 1'b0;
    #1;
    check_output("iso_async_reset", isolated, 0);
    isolate = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef AXI_FIFO_DRAIN_TIMEOUT_EN
    // Drain timeout with B withheld for longer than the threshold.
    send_aw(32'h7000_0000, 1);
    send_w(32'h7000_0001, 1, 1);
    isolate = 1'b1;
    tick();
    repeat (15) tick();
    check_output("tmo_before", timeout, 0);
    tick();
    check_output("tmo_hit", timeout, 1);
    send_b(4'h7);
    check_output("tmo_sticky", timeout, 1);
    tick();
    check_output("tmo_clear", timeout, 0);
    check_output("tmo_iso", isolated, 1);
    isolate = 1'b0;
    tick();
`endif

    tick();
    check_output("aw_q_empty", aw_q.size(), 0);
    check_output("w_q_empty", w_q.size(), 0);
    check_output("ar_q_empty", ar_q.size(), 0);
    check_output("b_q_empty", b_q.size(), 0);
    check_output("r_q_empty", r_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_fifo_drain_ctrl.md
AXI_FIFO_DRAIN_CTRL -- requirements
Module: axi_fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter MaxTxn, default 32'd8, giving max outstanding transactions per direction (write, read); must be >= 1.
REQ-002 SHALL have parameter TimeoutCycles, default 32'd1024, giving drain timeout threshold (used only under REQ-031).
REQ-003 SHALL have parameters axi_req_t and axi_resp_t, default logic, giving the AXI request/response structs.
REQ-004 SHALL have clk_i  input  1  clock; one clock domain only.
REQ-005 SHALL have rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have isolate_i  input  1  request to drain and isolate the downstream FIFO path.
REQ-007 SHALL have isolated_o  output  1  high while the path is isolated and empty of outstanding traffic.
REQ-008 SHALL have slv_req_i  input  axi_req_t  upstream request; slv_resp_o  output  axi_resp_t  upstream response.
REQ-009 SHALL have mst_req_o  output  axi_req_t  request toward FIFO; mst_resp_i  input  axi_resp_t  response from FIFO.

Function
REQ-010 SHALL pass all payload fields (aw, w, ar, b, r) through combinationally; only valid/ready are gated.
REQ-011 SHALL keep counters wr_cnt, rd_cnt, w_cnt, each $clog2(MaxTxn+1) bits wide.
REQ-012 wr_cnt SHALL +1 on downstream AW handshake, -1 on upstream B handshake; both in one cycle: unchanged.
REQ-013 rd_cnt SHALL +1 on downstream AR handshake, -1 on upstream R handshake with r.last; both: unchanged.
REQ-014 w_cnt SHALL +1 on downstream AW handshake, -1 on downstream W handshake with w.last; both: unchanged.
REQ-015 SHALL block AW (upstream aw_ready=0, downstream aw_valid=0) when wr_cnt==MaxTxn; same for AR with rd_cnt==MaxTxn; counters never overflow or underflow.
REQ-016 SHALL implement states NORMAL, DRAIN, ISOLATED.
REQ-017 NORMAL: AW/AR forwarded subject to REQ-015; W, B, R forwarded unconditionally.
REQ-018 NORMAL -> DRAIN when isolate_i=1 at clock edge.
REQ-019 DRAIN: AW and AR gated (upstream ready=0, downstream valid=0); gating effective same cycle state is DRAIN; B and R forwarded.
REQ-020 DRAIN: W forwarded only while w_cnt>0; otherwise w_valid downstream=0, w_ready upstream=0.
REQ-021 DRAIN -> ISOLATED when wr_cnt, rd_cnt, w_cnt all 0 and isolate_i=1; DRAIN -> NORMAL when isolate_i=0 (takes priority).
REQ-022 ISOLATED: all five valid/ready pairs gated to 0 in both directions; isolated_o=1 (registered, state-decoded).
REQ-023 ISOLATED -> NORMAL when isolate_i=0; isolated_o falls in the same cycle the state leaves ISOLATED.
REQ-024 Entering DRAIN with all counters already 0 SHALL reach ISOLATED one cycle later (latency isolate_i->isolated_o = 2 edges minimum).
REQ-025 A handshake in progress (valid=1, ready=0 downstream) at NORMAL->DRAIN SHALL be dropped from gating view only for AW/AR; upstream must not see ready=1 for it.

Reset
REQ-026 On rst_ni=0, state SHALL be NORMAL, all counters 0, isolated_o=0, asynchronously.
REQ-027 Reset mid-DRAIN or mid-ISOLATED SHALL return to NORMAL with counters cleared; no handshake completes during reset.
REQ-028 During reset, all gated valid/ready outputs SHALL be those of NORMAL with zero counters.

Configuration
REQ-029 Macro AXI_FIFO_DRAIN_TIMEOUT_EN SHALL select drain timeout support.
REQ-030 Without it: no timeout logic, no timeout_o port; DRAIN may last indefinitely.
REQ-031 With it: port timeout_o output 1; cycle counter cleared on DRAIN entry, increments each DRAIN cycle, saturates; timeout_o=1 (sticky) when count reaches TimeoutCycles, cleared on leaving DRAIN or reset; state machine behaviour otherwise unchanged.

Verification
REQ-032 Idle path, isolate_i 0->1 -> isolated_o=1 exactly 2 edges later, all valids/readies 0.
REQ-033 MaxTxn=2, 3 AWs issued, no B returned -> third AW sees aw_ready=0; after one B, third AW accepted.
REQ-034 2 AW accepted, isolate_i=1, W bursts of 4 beats each pending -> all 8 W beats forwarded, extra W blocked, isolated_o=1 only after both B and last beats.
REQ-035 Same-cycle AR handshake and R last handshake with rd_cnt=1 -> rd_cnt stays 1, no isolation.
REQ-036 isolate_i deasserted mid-DRAIN with wr_cnt=1 -> NORMAL next cycle, AW accepted again; rst_ni low mid-ISOLATED -> isolated_o=0 immediately.
REQ-037 With AXI_FIFO_DRAIN_TIMEOUT_EN, TimeoutCycles=16, B withheld -> timeout_o=1 after 16 DRAIN cycles, cleared when B returns and ISOLATED reached.
